// File: rtl/keen_writeback_arbiter_pkg.sv
// keen_pkg: shared writeback defaults, register-address type and request record.
package keen_pkg;
    localparam int DEFAULT_XLEN = 32;
    localparam int DEFAULT_REGISTERS = 32;
    localparam int DEFAULT_ADDRESS_SIZE = $clog2(DEFAULT_REGISTERS);
    typedef logic [DEFAULT_ADDRESS_SIZE-1:0] reg_address_t;
    typedef struct packed {
        reg_address_t address;
        logic [DEFAULT_XLEN-1:0] data;
    } wb_request_t;
    // Index width that stays legal for a single-entry vector.
    function automatic int index_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/keen_writeback_arbiter_if.sv
// keen_writeback_arbiter_if: producer handshakes, issue-stage claims and the register-file write port.
interface keen_writeback_arbiter_if import keen_pkg::*; #(
    parameter int PRODUCERS = 2,
    parameter int XLEN = DEFAULT_XLEN,
    parameter int REGISTERS = DEFAULT_REGISTERS
);
    localparam int ADDRESS_SIZE = $clog2(REGISTERS);
    logic req_valid [0:PRODUCERS-1];
    logic req_ready [0:PRODUCERS-1];
    logic [ADDRESS_SIZE-1:0] req_address [0:PRODUCERS-1];
    logic [XLEN-1:0] req_data [0:PRODUCERS-1];
    logic claim_valid;
    logic [ADDRESS_SIZE-1:0] claim_address;
    logic [ADDRESS_SIZE-1:0] write_address;
    logic [XLEN-1:0] write_data;
    logic write_enable;
    logic [REGISTERS-1:0] pending;
    modport master (
        output req_valid, req_address, req_data, claim_valid, claim_address,
        input req_ready, write_address, write_data, write_enable, pending
    );
    modport slave (
        input req_valid, req_address, req_data, claim_valid, claim_address,
        output req_ready, write_address, write_data, write_enable, pending
    );
endinterface

// File: rtl/keen_writeback_arbiter_rr.sv
// keen_round_robin_arbiter: combinational grant of the first request strictly after the pointer.
module keen_round_robin_arbiter import keen_pkg::*; #(
    parameter int N = 2,
    localparam int IW = index_width(N)
) (
    input  logic [N-1:0]  i_request,
    input  logic [IW-1:0] i_pointer,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_index,
    output logic          o_any
);
    // Scan from lowest to highest priority so the last hit is the winner.
    always_comb begin
        o_grant = '0;
        o_index = '0;
        o_any = 1'b0;
        for (int k = N; k >= 1; k--) begin
            if (i_request[(int'(i_pointer) + k) % N]) begin
                o_grant = N'(1) << ((int'(i_pointer) + k) % N);
                o_index = IW'((int'(i_pointer) + k) % N);
                o_any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/keen_writeback_arbiter.sv
// keen_writeback_arbiter: per-producer holding registers, round-robin write port and pending scoreboard.
// KEEN_WB_ZERO_DROP_EN drops address-0 results at acceptance instead of writing them.
module keen_writeback_arbiter import keen_pkg::*; #(
    parameter int PRODUCERS = 2,
    parameter int XLEN = DEFAULT_XLEN,
    parameter int REGISTERS = DEFAULT_REGISTERS,
    localparam int ADDRESS_SIZE = $clog2(REGISTERS),
    localparam int IW = index_width(PRODUCERS)
) (
    input logic clk,
    input logic reset,
    keen_writeback_arbiter_if.slave bus
);
`ifdef KEEN_WB_ZERO_DROP_EN
    localparam bit ZERO_DROP = 1'b1;
`else
    localparam bit ZERO_DROP = 1'b0;
`endif
    logic [PRODUCERS-1:0] r_held, w_load, w_grant;
    logic [ADDRESS_SIZE-1:0] r_address [PRODUCERS];
    logic [XLEN-1:0] r_data [PRODUCERS];
    logic [IW-1:0] r_pointer, w_index;
    logic w_any;
    logic [REGISTERS-1:0] r_pending, w_set, w_clear;
    logic r_write_enable;
    logic [ADDRESS_SIZE-1:0] r_write_address;
    logic [XLEN-1:0] r_write_data;

    keen_round_robin_arbiter #(.N(PRODUCERS)) u_rr (
        .i_request(r_held),
        .i_pointer(r_pointer),
        .o_grant(w_grant),
        .o_index(w_index),
        .o_any(w_any)
    );

    always_comb begin
        for (int i = 0; i < PRODUCERS; i++) begin
            bus.req_ready[i] = reset && !r_held[i];
            w_load[i] = bus.req_valid[i] && !r_held[i] && !(ZERO_DROP && bus.req_address[i] == '0);
        end
        w_set = (bus.claim_valid && bus.claim_address != '0) ? REGISTERS'(1) << bus.claim_address : '0;
        w_clear = w_any ? REGISTERS'(1) << r_address[w_index] : '0;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < PRODUCERS; i++) begin
            if (w_load[i]) begin
                r_address[i] <= bus.req_address[i];
                r_data[i] <= bus.req_data[i];
            end
        end
    end

    // A new claim outranks the clear from a grant to the same register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_held <= '0;
            r_pointer <= IW'(PRODUCERS - 1);
            r_pending <= '0;
            r_write_enable <= 1'b0;
            r_write_address <= '0;
            r_write_data <= '0;
        end else begin
            r_held <= (r_held & ~w_grant) | w_load;
            r_pending <= (r_pending & ~w_clear) | w_set;
            r_write_enable <= w_any;
            if (w_any) begin
                r_pointer <= w_index;
                r_write_address <= r_address[w_index];
                r_write_data <= r_data[w_index];
            end
        end
    end

    assign bus.write_enable = r_write_enable;
    assign bus.write_address = r_write_address;
    assign bus.write_data = r_write_data;
    assign bus.pending = r_pending;
endmodule

// File: doc/keen_writeback_arbiter.md
Name: keen_writeback_arbiter

Overview:
- Writer-side front end for the register file: collects results from PRODUCERS execution units and drives the single register-file write port.
- Each producer gets a one-entry holding register behind a valid/ready handshake. A round-robin arbiter selects one held entry per cycle and registers it onto the write port.
- Maintains a pending-write scoreboard so the issue stage can stall on destinations with writes in flight.

Parameters:
- PRODUCERS, 2, number of result sources (>=1).
- XLEN, 32, data width.
- REGISTERS, 32, architectural register count (power of two).
- ADDRESS_SIZE, $clog2(REGISTERS), localparam register index width.

Ports:
- clk  input  1  clock, all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1 [0:PRODUCERS-1]  producer result valid.
- req_ready  output  1 [0:PRODUCERS-1]  holding register free.
- req_address  input  ADDRESS_SIZE [0:PRODUCERS-1]  destination register.
- req_data  input  XLEN [0:PRODUCERS-1]  result value.
- claim_valid  input  1  issue stage reserves a destination this cycle.
- claim_address  input  ADDRESS_SIZE  reserved destination.
- write_address  output  ADDRESS_SIZE  register-file write address (registered).
- write_data  output  XLEN  register-file write data (registered).
- write_enable  output  1  register-file write strobe (registered).
- pending  output  REGISTERS  bit r set while register r has a claimed write not yet issued.

Behaviour:
- Reset (reset low, async): held[] = 0, round-robin pointer = PRODUCERS-1 (so producer 0 wins first), write_enable = 0, write_address = 0, write_data = 0, pending = 0. req_ready is forced 0 while reset is low.
- Handshake: req_ready[i] = !held[i] (combinational from state). An accept is req_valid[i] & req_ready[i] at a posedge, which loads address/data and sets held[i]. The producer must hold valid/address/data stable until accepted.
- Throughput: no same-cycle refill. A producer sustains one result every 2 cycles; aggregate write-port throughput is 1 per cycle.
- Arbitration, each cycle:
  - Grant the first held index strictly after the pointer, scanning circularly.
  - On a grant at a posedge: clear held[g], move the pointer to g, load write_address/write_data from entry g, set write_enable = 1.
  - With no held entries: write_enable = 0; write_address and write_data keep their old values; the pointer is unchanged.
- Latency: accept at edge k; the write appears on the port after edge k+1 at the earliest, i.e. 2 cycles from accept to write_enable high.
- Scoreboard:
  - claim_valid with claim_address != 0 sets pending[claim_address].
  - A grant clears pending[granted address] on the same edge the write is registered.
  - Claim and clear of the same address on the same edge: the set wins.
  - Claim of address 0 is ignored; pending[0] is constant 0.
  - Clearing an address whose bit is already clear is harmless.
- Ordering: writes to the same address from different producers complete in grant order only. Preventing this is the issue stage's job, using pending.
- Address 0 (macro absent): the write is issued normally with write_enable = 1; the register file discards its effect on reads.
- Reset mid-operation: held entries are discarded and not written. pending is cleared, so producers must also be flushed.

Optional Feature:
- Macro: KEEN_WB_ZERO_DROP_EN.
- Defined: an accepted request with req_address == 0 is dropped at acceptance. held is never set, so req_ready stays 1 and the next request can be accepted on the next edge. No write-port cycle is consumed; write_enable never asserts with write_address == 0.
- Undefined: address-0 requests are treated like any other (see Behaviour).

Decomposition:
- Shared package keen_pkg holds:
  - default XLEN/REGISTERS constants;
  - the register-address typedef (ADDRESS_SIZE bits);
  - a writeback request struct {address, data}, shared with the execution units.
- Sub-module keen_round_robin_arbiter: parameter N; request vector and pointer in, one-hot grant and grant index out; purely combinational. It is reused later by the memory port.

Test Plan:
- Reset, then producer 0 sends addr 5 / data 0xDEADBEEF at edge 1 -> req_ready[0] = 0 during cycle 1; write_enable = 1, write_address = 5, write_data = 0xDEADBEEF after edge 2; req_ready[0] = 1 again after edge 2.
- Both producers valid every cycle with addrs 1 and 2 -> the write port alternates 1, 2, 1, 2 with write_enable continuously high from cycle 2.
- claim addr 7, then producer 1 writes addr 7 -> pending[7] = 1 from the claim edge until the grant edge, 0 after.
- Claim addr 3 on the same edge a write to addr 3 is granted -> pending[3] stays 1.
- Assert reset low mid-cycle with 2 entries held -> all outputs go 0 immediately, with no write afterward.
- With KEEN_WB_ZERO_DROP_EN, producer 0 sends addr 0 then addr 4 back-to-back -> only the addr-4 write appears, after edge 3; req_ready[0] stays 1 through the addr-0 accept.
